// File: rtl/falafel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : falafel_pkg
//  Brief    : Shared types, constants and the allocation-size helper used by
//             the falafel allocator and its LSU.
//  Revision : 1.0 - initial release
// ============================================================================
package falafel_pkg;

  localparam int DATA_W    = 32;
  localparam int WORD_SIZE = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [DATA_W:0]   wide_t;

  localparam word_t NULL_PTR  = '0;
  localparam word_t EMPTY_KEY = '0;

  typedef enum logic [2:0] {
    LOAD_WORD   = 3'd0,
    STORE_WORD  = 3'd1,
    LOAD_BLOCK  = 3'd2,
    STORE_BLOCK = 3'd3,
    LOCK        = 3'd4,
    UNLOCK      = 3'd5
  } lsu_op_e;

  // Free-block layout in memory: size at addr, next_ptr at addr+WORD_SIZE.
  typedef struct packed {
    word_t size;
    word_t next_ptr;
  } free_block_t;

  // Header word plus payload, rounded up to a double-word, at least min_size.
  // Result is {overflow, eff}; eff is meaningless when overflow is set.
  function automatic wide_t align_alloc_size(input word_t size, input word_t min_size);
    wide_t sum;
    wide_t aligned;
    word_t eff;
    sum     = {1'b0, size} + wide_t'(WORD_SIZE + 2 * WORD_SIZE - 1);
    aligned = sum & ~wide_t'(2 * WORD_SIZE - 1);
    eff     = aligned[DATA_W-1:0];
    if (!aligned[DATA_W] && (eff < min_size)) begin
      eff = min_size;
    end
    return {aligned[DATA_W], eff};
  endfunction

endpackage
`default_nettype wire

// File: rtl/falafel_alloc_core.sv
`default_nettype none
// ============================================================================
//  Module   : falafel_alloc_core
//  Brief    : First-fit allocator engine. Takes the allocator lock, walks the
//             singly linked free list through the LSU, splits or unlinks the
//             first fitting block, writes its size header, releases the lock
//             and returns the payload pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module falafel_alloc_core
  import falafel_pkg::*;
#(
  parameter word_t       HEAD_ADDR      = 32'h0000_0100,
  parameter word_t       LOCK_ADDR      = 32'h0000_0104,
  parameter word_t       LOCK_ID        = 32'h0000_0001,
  parameter int unsigned MIN_BLOCK_SIZE = 16,
  parameter int unsigned MAX_WALK       = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // allocation request / response
  input  logic        req_val_i,
  output logic        req_rdy_o,
  input  word_t       req_size_i,
  output logic        rsp_val_o,
  input  logic        rsp_rdy_i,
  output word_t       rsp_ptr_o,
  // LSU request
  output logic        lsu_req_val_o,
  input  logic        lsu_req_rdy_i,
  output lsu_op_e     lsu_req_op_o,
  output word_t       lsu_req_addr_o,
  output word_t       lsu_req_word_o,
  output word_t       lsu_req_lock_id_o,
  output free_block_t lsu_req_block_o,
  // LSU response
  input  logic        lsu_rsp_val_i,
  output logic        lsu_rsp_rdy_o,
  input  word_t       lsu_rsp_word_i,
  input  free_block_t lsu_rsp_block_i
);

  localparam int WALK_W = $clog2(MAX_WALK + 1);

  // Every LSU operation is an ISSUE state followed by a WAIT state.
  localparam logic [4:0] S_IDLE        = 5'd0;
  localparam logic [4:0] S_LOCK_ISS    = 5'd1;
  localparam logic [4:0] S_LOCK_WAIT   = 5'd2;
  localparam logic [4:0] S_HEAD_ISS    = 5'd3;
  localparam logic [4:0] S_HEAD_WAIT   = 5'd4;
  localparam logic [4:0] S_CHECK       = 5'd5;
  localparam logic [4:0] S_BLK_ISS     = 5'd6;
  localparam logic [4:0] S_BLK_WAIT    = 5'd7;
  localparam logic [4:0] S_EVAL        = 5'd8;
  localparam logic [4:0] S_SPLIT_ISS   = 5'd9;
  localparam logic [4:0] S_SPLIT_WAIT  = 5'd10;
  localparam logic [4:0] S_LINK_ISS    = 5'd11;
  localparam logic [4:0] S_LINK_WAIT   = 5'd12;
  localparam logic [4:0] S_HDR_ISS     = 5'd13;
  localparam logic [4:0] S_HDR_WAIT    = 5'd14;
  localparam logic [4:0] S_UNLOCK_ISS  = 5'd15;
  localparam logic [4:0] S_UNLOCK_WAIT = 5'd16;
  localparam logic [4:0] S_RESPOND     = 5'd17;

  logic [4:0]        state_q, state_d;
  word_t             eff_q, eff_d;
  word_t             cur_q, cur_d;
  word_t             link_q, link_d;
  logic [WALK_W-1:0] walk_q, walk_d;
  free_block_t       blk_q, blk_d;
  logic              fail_q, fail_d;

  logic              rsp_val_q, rsp_val_d;
  word_t             rsp_ptr_q, rsp_ptr_d;
  logic              lsu_req_val_q, lsu_req_val_d;
  lsu_op_e           lsu_req_op_q, lsu_req_op_d;
  word_t             lsu_req_addr_q, lsu_req_addr_d;
  word_t             lsu_req_word_q, lsu_req_word_d;
  free_block_t       lsu_req_block_q, lsu_req_block_d;

  wide_t             w_alloc;
  logic              w_ovf;
  word_t             w_eff;
  logic              w_fits;
  word_t             w_remainder;
  logic              w_split;
  word_t             w_split_addr;

  // Request sizing and the fit / split decision on the loaded block.
  always_comb begin
    w_alloc      = align_alloc_size(req_size_i, word_t'(MIN_BLOCK_SIZE));
    w_ovf        = w_alloc[DATA_W];
    w_eff        = w_alloc[DATA_W-1:0];
    w_fits       = (blk_q.size >= eff_q);
    w_remainder  = blk_q.size - eff_q;
    w_split      = w_fits && (w_remainder >= word_t'(MIN_BLOCK_SIZE));
    w_split_addr = cur_q + eff_q;
  end

  // State register and all datapath / output flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      eff_q           <= '0;
      cur_q           <= '0;
      link_q          <= '0;
      walk_q          <= '0;
      blk_q           <= '0;
      fail_q          <= 1'b0;
      rsp_val_q       <= 1'b0;
      rsp_ptr_q       <= '0;
      lsu_req_val_q   <= 1'b0;
      lsu_req_op_q    <= LOAD_WORD;
      lsu_req_addr_q  <= '0;
      lsu_req_word_q  <= '0;
      lsu_req_block_q <= '0;
    end else begin
      state_q         <= state_d;
      eff_q           <= eff_d;
      cur_q           <= cur_d;
      link_q          <= link_d;
      walk_q          <= walk_d;
      blk_q           <= blk_d;
      fail_q          <= fail_d;
      rsp_val_q       <= rsp_val_d;
      rsp_ptr_q       <= rsp_ptr_d;
      lsu_req_val_q   <= lsu_req_val_d;
      lsu_req_op_q    <= lsu_req_op_d;
      lsu_req_addr_q  <= lsu_req_addr_d;
      lsu_req_word_q  <= lsu_req_word_d;
      lsu_req_block_q <= lsu_req_block_d;
    end
  end

  // Next-state and list-walk bookkeeping.
  always_comb begin
    state_d = state_q;
    eff_d   = eff_q;
    cur_d   = cur_q;
    link_d  = link_q;
    walk_d  = walk_q;
    blk_d   = blk_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (req_val_i) begin
          eff_d = w_eff;
          if ((req_size_i == '0) || w_ovf) begin
            fail_d  = 1'b1;
            state_d = S_RESPOND;
          end else begin
            fail_d  = 1'b0;
            state_d = S_LOCK_ISS;
          end
        end
      end
      S_LOCK_ISS:   if (lsu_req_rdy_i) state_d = S_LOCK_WAIT;
      S_LOCK_WAIT:  if (lsu_rsp_val_i) state_d = S_HEAD_ISS;
      S_HEAD_ISS:   if (lsu_req_rdy_i) state_d = S_HEAD_WAIT;
      S_HEAD_WAIT: begin
        if (lsu_rsp_val_i) begin
          cur_d   = lsu_rsp_word_i;
          link_d  = HEAD_ADDR;
          walk_d  = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((cur_q == NULL_PTR) || (walk_q == WALK_W'(MAX_WALK))) begin
          fail_d  = 1'b1;
          state_d = S_UNLOCK_ISS;
        end else begin
          state_d = S_BLK_ISS;
        end
      end
      S_BLK_ISS:    if (lsu_req_rdy_i) state_d = S_BLK_WAIT;
      S_BLK_WAIT: begin
        if (lsu_rsp_val_i) begin
          blk_d   = lsu_rsp_block_i;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!w_fits) begin
          // The next block's link field lives in the current block.
          link_d  = cur_q + word_t'(WORD_SIZE);
          cur_d   = blk_q.next_ptr;
          walk_d  = walk_q + WALK_W'(1);
          state_d = S_CHECK;
        end else if (w_split) begin
          state_d = S_SPLIT_ISS;
        end else begin
          state_d = S_LINK_ISS;
        end
      end
      S_SPLIT_ISS:   if (lsu_req_rdy_i) state_d = S_SPLIT_WAIT;
      S_SPLIT_WAIT:  if (lsu_rsp_val_i) state_d = S_LINK_ISS;
      S_LINK_ISS:    if (lsu_req_rdy_i) state_d = S_LINK_WAIT;
      S_LINK_WAIT:   if (lsu_rsp_val_i) state_d = S_HDR_ISS;
      S_HDR_ISS:     if (lsu_req_rdy_i) state_d = S_HDR_WAIT;
      S_HDR_WAIT:    if (lsu_rsp_val_i) state_d = S_UNLOCK_ISS;
      S_UNLOCK_ISS:  if (lsu_req_rdy_i) state_d = S_UNLOCK_WAIT;
      S_UNLOCK_WAIT: if (lsu_rsp_val_i) state_d = S_RESPOND;
      S_RESPOND:     if (rsp_rdy_i) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered so that the
  // LSU request appears with no extra cycle and holds while stalled.
  always_comb begin
    lsu_req_val_d   = 1'b0;
    lsu_req_op_d    = lsu_req_op_q;
    lsu_req_addr_d  = lsu_req_addr_q;
    lsu_req_word_d  = lsu_req_word_q;
    lsu_req_block_d = lsu_req_block_q;
    rsp_val_d       = 1'b0;
    rsp_ptr_d       = rsp_ptr_q;
    case (state_d)
      S_LOCK_ISS: begin
        lsu_req_val_d  = 1'b1;
        lsu_req_op_d   = LOCK;
        lsu_req_addr_d = LOCK_ADDR;
      end
      S_HEAD_ISS: begin
        lsu_req_val_d  = 1'b1;
        lsu_req_op_d   = LOAD_WORD;
        lsu_req_addr_d = HEAD_ADDR;
      end
      S_BLK_ISS: begin
        lsu_req_val_d  = 1'b1;
        lsu_req_op_d   = LOAD_BLOCK;
        lsu_req_addr_d = cur_d;
      end
      S_SPLIT_ISS: begin
        // Tail of the split block becomes a new free block.
        lsu_req_val_d            = 1'b1;
        lsu_req_op_d             = STORE_BLOCK;
        lsu_req_addr_d           = w_split_addr;
        lsu_req_block_d.size     = w_remainder;
        lsu_req_block_d.next_ptr = blk_q.next_ptr;
      end
      S_LINK_ISS: begin
        // Predecessor link skips the allocated block.
        lsu_req_val_d  = 1'b1;
        lsu_req_op_d   = STORE_WORD;
        lsu_req_addr_d = link_q;
        lsu_req_word_d = w_split ? w_split_addr : blk_q.next_ptr;
      end
      S_HDR_ISS: begin
        lsu_req_val_d  = 1'b1;
        lsu_req_op_d   = STORE_WORD;
        lsu_req_addr_d = cur_q;
        lsu_req_word_d = w_split ? eff_q : blk_q.size;
      end
      S_UNLOCK_ISS: begin
        lsu_req_val_d  = 1'b1;
        lsu_req_op_d   = UNLOCK;
        lsu_req_addr_d = LOCK_ADDR;
      end
      S_RESPOND: begin
        rsp_val_d = 1'b1;
        rsp_ptr_d = fail_d ? NULL_PTR : (cur_q + word_t'(WORD_SIZE));
      end
      default: ;
    endcase
  end

  assign req_rdy_o         = (state_q == S_IDLE);
  assign rsp_val_o         = rsp_val_q;
  assign rsp_ptr_o         = rsp_ptr_q;
  assign lsu_req_val_o     = lsu_req_val_q;
  assign lsu_req_op_o      = lsu_req_op_q;
  assign lsu_req_addr_o    = lsu_req_addr_q;
  assign lsu_req_word_o    = lsu_req_word_q;
  assign lsu_req_block_o   = lsu_req_block_q;
  assign lsu_req_lock_id_o = LOCK_ID;
  assign lsu_rsp_rdy_o     = (state_q == S_LOCK_WAIT)  || (state_q == S_HEAD_WAIT) ||
                             (state_q == S_BLK_WAIT)   || (state_q == S_SPLIT_WAIT) ||
                             (state_q == S_LINK_WAIT)  || (state_q == S_HDR_WAIT) ||
                             (state_q == S_UNLOCK_WAIT);

endmodule
`default_nettype wire
